fetch_queue: RTL and testbench

Instruction fetch queue between the PC-increment/instruction-memory stage and dual-issue decode. Each cycle it accepts one `{pc, instruction}` pair from fetch and presents the two oldest entries to decode. Decode consumes 0, 1 or 2 entries per cycle. The block decouples fetch from decode stalls and discards all in-flight instructions on a branch/exception flush.

---
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one {pc, ins} push per cycle, two oldest entries presented to dual-issue decode.
// Optional stall statistics counter enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push_valid,
   input  logic [31:0]   push_pc,
   input  logic [31:0]   push_ins,
   output logic          push_ready,
   input  logic [1:0]    pop_count,
   output logic          out0_valid,
   output logic [31:0]   out0_pc,
   output logic [31:0]   out0_ins,
   output logic          out1_valid,
   output logic [31:0]   out1_pc,
   output logic [31:0]   out1_ins,
   output logic [AW:0]   count
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]   stall_count
`endif
);

   localparam int unsigned CW   = AW + 1;
   localparam logic [AW:0] FULL = CW'(DEPTH);
   localparam logic [AW:0] TWO  = CW'(2);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head_p1;
   logic          push_acc;
   logic [1:0]    pop_clip;
   logic [AW:0]   pop_req;
   logic [AW:0]   pop_eff;

   // Pop request is clipped to 2, then limited to what is actually held.
   always_comb begin
      push_ready = (count != FULL);
      push_acc   = push_valid && push_ready && !flush;
      pop_clip   = (pop_count == 2'd3) ? 2'd2 : pop_count;
      pop_req    = CW'(pop_clip);
      pop_eff    = (pop_req > count) ? count : pop_req;
      head_p1    = head + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_acc) begin
            mem[tail] <= '{pc: push_pc, ins: push_ins};
            tail      <= tail + AW'(1);
         end
         head  <= head + AW'(pop_eff);
         count <= count + CW'(push_acc) - pop_eff;
      end
   end

   // Read ports depend on registered state only; data is zeroed when the slot is empty.
   always_comb begin
      out0_valid = (count != '0);
      out1_valid = (count >= TWO);
      out0_pc    = out0_valid ? mem[head].pc     : '0;
      out0_ins   = out0_valid ? mem[head].ins    : '0;
      out1_pc    = out1_valid ? mem[head_p1].pc  : '0;
      out1_ins   = out1_valid ? mem[head_p1].ins : '0;
   end

`ifdef FETCH_QUEUE_STATS_EN
   // Counts cycles where fetch is held back by a full queue; survives flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (push_valid && !push_ready && !flush) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver queues hand-computed post-edge state, monitor compares at negedge.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, flush, push_valid, push_ready;
   logic [31:0] push_pc, push_ins;
   logic [1:0]  pop_count;
   logic        out0_valid, out1_valid;
   logic [31:0] out0_pc, out0_ins, out1_pc, out1_ins;
   logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] stall_count;
`endif

   fetch_queue #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .push_valid(push_valid), .push_pc(push_pc), .push_ins(push_ins), .push_ready(push_ready),
      .pop_count(pop_count),
      .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_ins(out0_ins),
      .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_ins(out1_ins),
      .count(count)
`ifdef FETCH_QUEUE_STATS_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [2:0]  cnt;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [31:0] stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_id = 0;

   // Instruction word tied to its PC so data ordering is checked alongside the PC.
   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0013;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   // Expected pc 0 marks an empty slot in the vectors.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("count",      e.id, 32'(count),      32'(e.cnt));
         chk("push_ready", e.id, 32'(push_ready), 32'(e.cnt != 3'd4));
         chk("out0_valid", e.id, 32'(out0_valid), 32'(e.pc0 != 0));
         chk("out0_pc",    e.id, out0_pc,         e.pc0);
         chk("out0_ins",   e.id, out0_ins,        (e.pc0 != 0) ? ins_of(e.pc0) : 32'h0);
         chk("out1_valid", e.id, 32'(out1_valid), 32'(e.pc1 != 0));
         chk("out1_pc",    e.id, out1_pc,         e.pc1);
         chk("out1_ins",   e.id, out1_ins,        (e.pc1 != 0) ? ins_of(e.pc1) : 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
         chk("stall_count", e.id, stall_count,    e.stall);
`endif
      end
   end

   task automatic step(input logic rst, input logic fl, input logic pv, input logic [31:0] pc,
                       input logic [1:0] pop, input logic [2:0] ecnt, input logic [31:0] epc0,
                       input logic [31:0] epc1, input logic [31:0] estall);
      exp_t e;
      @(negedge clk);
      reset      = rst;
      flush      = fl;
      push_valid = pv;
      push_pc    = pc;
      push_ins   = ins_of(pc);
      pop_count  = pop;
      @(posedge clk);
      step_id++;
      e.id = step_id; e.cnt = ecnt; e.pc0 = epc0; e.pc1 = epc1; e.stall = estall;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog step %0d: got timeout expected finish", step_id);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_pc = '0; push_ins = '0; pop_count = '0;
      // reset then idle
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      // fill and refuse
      step(0, 0, 1, 32'h00400020, 0, 1, 32'h00400020, 32'h0,        0);
      step(0, 0, 1, 32'h00400024, 0, 2, 32'h00400020, 32'h00400024, 0);
      step(0, 0, 1, 32'h00400028, 0, 3, 32'h00400020, 32'h00400024, 0);
      step(0, 0, 1, 32'h0040002C, 0, 4, 32'h00400020, 32'h00400024, 0);
      step(0, 0, 1, 32'h00400030, 0, 4, 32'h00400020, 32'h00400024, 1);
      // dual pop with push across wrap
      step(0, 0, 1, 32'h00400030, 2, 2, 32'h00400028, 32'h0040002C, 2);
      step(0, 0, 1, 32'h00400030, 2, 1, 32'h00400030, 32'h0,        2);
      step(0, 0, 1, 32'h00400034, 2, 1, 32'h00400034, 32'h0,        2);
      step(0, 0, 1, 32'h00400038, 2, 1, 32'h00400038, 32'h0,        2);
      step(0, 0, 1, 32'h0040003C, 2, 1, 32'h0040003C, 32'h0,        2);
      step(0, 0, 1, 32'h00400040, 2, 1, 32'h00400040, 32'h0,        2);
      // over-pop
      step(0, 0, 0, 32'h0,        2, 0, 32'h0,        32'h0,        2);
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        2);
      // flush priority
      step(0, 0, 1, 32'h00400050, 0, 1, 32'h00400050, 32'h0,        2);
      step(0, 0, 1, 32'h00400054, 0, 2, 32'h00400050, 32'h00400054, 2);
      step(0, 0, 1, 32'h00400058, 0, 3, 32'h00400050, 32'h00400054, 2);
      step(0, 1, 1, 32'h00400100, 1, 0, 32'h0,        32'h0,        2);
      step(0, 0, 1, 32'h00400200, 0, 1, 32'h00400200, 32'h0,        2);
      step(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        2);
      // pop_count 3 acts as 2, then push+pop at occupancy 1
      step(0, 0, 1, 32'h00400300, 0, 1, 32'h00400300, 32'h0,        2);
      step(0, 0, 1, 32'h00400304, 0, 2, 32'h00400300, 32'h00400304, 2);
      step(0, 0, 1, 32'h00400308, 0, 3, 32'h00400300, 32'h00400304, 2);
      step(0, 0, 0, 32'h0,        3, 1, 32'h00400308, 32'h0,        2);
      step(0, 0, 1, 32'h0040030C, 1, 1, 32'h0040030C, 32'h0,        2);
      // reset wins over a push
      step(1, 0, 1, 32'h00400500, 0, 0, 32'h0,        32'h0,        0);
      // stall statistics: fill, hold full 7 cycles, flush, reset
      step(0, 0, 1, 32'h00400600, 0, 1, 32'h00400600, 32'h0,        0);
      step(0, 0, 1, 32'h00400604, 0, 2, 32'h00400600, 32'h00400604, 0);
      step(0, 0, 1, 32'h00400608, 0, 3, 32'h00400600, 32'h00400604, 0);
      step(0, 0, 1, 32'h0040060C, 0, 4, 32'h00400600, 32'h00400604, 0);
      for (int k = 1; k <= 7; k++) begin
         step(0, 0, 1, 32'h00400610, 0, 4, 32'h00400600, 32'h00400604, 32'(k));
      end
      step(0, 1, 1, 32'h00400610, 0, 0, 32'h0,        32'h0,        7);
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        7);
      step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      repeat (2) @(negedge clk);
      chk("drain", step_id, 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
